// File: rtl/lsu_ctrl_pkg.sv
// Shared core header: ALU op codes, LSU state encoding and access-size codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lsu_ctrl_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_ops_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        WAIT_R = 3'd2,
        DONE   = 3'd3,
        ERR    = 3'd4
    } lsu_state_t;

    localparam logic [2:0] SZ_B  = 3'b001;
    localparam logic [2:0] SZ_H  = 3'b010;
    localparam logic [2:0] SZ_W  = 3'b011;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: byte enables, store replication, load extract/extend, legality check.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module lsu_align
    import lsu_ctrl_pkg::*;
(
    input  logic [2:0]  chk_size,
    input  logic [1:0]  chk_lo,
    input  logic [2:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_raw,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misalign,
    output logic        size_ok
);

    logic [31:0] shifted;

    // Legality of the access presented by decode this cycle.
    always_comb begin
        size_ok  = 1'b0;
        misalign = 1'b0;
        case (chk_size)
            SZ_B, SZ_BU: size_ok = 1'b1;
            SZ_H, SZ_HU: begin
                size_ok  = 1'b1;
                misalign = chk_lo[0];
            end
            SZ_W: begin
                size_ok  = 1'b1;
                misalign = (chk_lo != 2'b00);
            end
            default: size_ok = 1'b0;
        endcase
    end

    // Lane steering for the latched access: enables, store copy, load alignment.
    always_comb begin
        shifted   = rdata_raw >> {addr_lo, 3'b000};
        be        = 4'b0000;
        wdata_rep = 32'h0;
        rdata_ext = 32'h0;
        case (size)
            SZ_B: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
            end
            SZ_BU: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {24'h0, shifted[7:0]};
            end
            SZ_H: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
            end
            SZ_HU: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {16'h0, shifted[15:0]};
            end
            SZ_W: begin
                be        = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = shifted;
            end
            default: begin
                be        = 4'b0000;
                wdata_rep = 32'h0;
                rdata_ext = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: turns decode rd_en/wr_en into one handshaked data-bus access.
// Latency: store 1 cycle + gnt wait, load 1 cycle + gnt + rvalid wait, then a 1-cycle DONE.
// Backpressure: bus_req held stable until bus_gnt; core is stalled until done, aborts after TIMEOUT_CYCLES.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [2:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        done,
    output logic        lsu_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [2:0]       size_q;
    logic             we_q;
    logic [31:0]      rdata_q;

    logic             start;
    logic             bad;
    logic             misalign;
    logic             size_ok;
    logic [3:0]       be;
    logic [31:0]      wdata_rep;
    logic [31:0]      rdata_ext;

    // Legality is judged on the live decode inputs; lane steering uses the latched access.
    lsu_align u_align (
        .chk_size  (size),
        .chk_lo    (addr[1:0]),
        .size      (size_q),
        .addr_lo   (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata_raw (bus_rdata),
        .be        (be),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext),
        .misalign  (misalign),
        .size_ok   (size_ok)
    );

    assign start = (rd_en | wr_en) && (state_q == IDLE);
    assign bad   = (rd_en & wr_en)
                 | (wr_en & ((size == SZ_BU) | (size == SZ_HU)))
                 | ~size_ok
                 | misalign;

    // Next state and outputs; reset forces every output low regardless of state.
    always_comb begin
        state_d   = state_q;
        stall     = 1'b0;
        done      = 1'b0;
        lsu_err   = 1'b0;
        rdata     = rdata_q;
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = 32'h0;
        bus_be    = 4'b0000;
        bus_wdata = 32'h0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (bad) begin
                        lsu_err = 1'b1;
                        done    = 1'b1;
                        rdata   = 32'h0;
                    end else begin
                        stall   = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                stall     = 1'b1;
                bus_req   = 1'b1;
                bus_we    = we_q;
                bus_addr  = {addr_q[31:2], 2'b00};
                bus_be    = be;
                bus_wdata = wdata_rep;
                if (bus_gnt) begin
                    state_d = we_q ? DONE : WAIT_R;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = ERR;
                end
            end
            WAIT_R: begin
                stall = 1'b1;
                if (bus_rvalid) begin
                    state_d = DONE;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = ERR;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            ERR: begin
                lsu_err = 1'b1;
                done    = 1'b1;
                rdata   = 32'h0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            state_d   = IDLE;
            stall     = 1'b0;
            done      = 1'b0;
            lsu_err   = 1'b0;
            rdata     = 32'h0;
            bus_req   = 1'b0;
            bus_we    = 1'b0;
            bus_addr  = 32'h0;
            bus_be    = 4'b0000;
            bus_wdata = 32'h0;
        end
    end

    // State register, access latch, timeout counter and load-result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            size_q  <= 3'b000;
            we_q    <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (start && !bad) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                size_q  <= size;
                we_q    <= wr_en;
                cnt_q   <= '0;
            end else if ((state_q == REQ) || (state_q == WAIT_R)) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if ((state_q == WAIT_R) && bus_rvalid) begin
                rdata_q <= rdata_ext;
            end
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: loads, stores, illegal accesses, timeout and mid-access reset.
// Latency: drives inputs 1 time unit after posedge, samples on negedge.
// Backpressure: bus_gnt/bus_rvalid scheduled per access by cycle index.
module tb_lsu_ctrl;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        done;
    logic        lsu_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int total;
    int nbad;

    int          obs_stall;
    int          obs_req;
    logic        obs_we;
    logic [31:0] obs_addr;
    logic [3:0]  obs_be;
    logic [31:0] obs_wdata;
    logic [31:0] obs_rdata;
    logic        obs_err;
    logic        obs_stall_done;
    logic        obs_req_done;
    logic        obs_fin;

    lsu_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .size       (size),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .rdata      (rdata),
        .done       (done),
        .lsu_err    (lsu_err),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            nbad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One access from the IDLE cycle through done; gnt at cycle 1+gnt_dly, rvalid the cycle after.
    task automatic run_access(input logic we, input logic [2:0] sz, input logic [31:0] a,
                              input logic [31:0] wd, input int gnt_dly, input logic [31:0] rbus);
        obs_stall = 0; obs_req = 0; obs_we = 1'b0; obs_addr = 32'h0; obs_be = 4'h0;
        obs_wdata = 32'h0; obs_rdata = 32'h0; obs_err = 1'b0;
        obs_stall_done = 1'b0; obs_req_done = 1'b0; obs_fin = 1'b0;
        rd_en = !we; wr_en = we; size = sz; addr = a; wdata = wd; bus_rdata = rbus;
        for (int i = 0; i < 40; i++) begin
            bus_gnt    = (i == 1 + gnt_dly);
            bus_rvalid = !we && (i == 2 + gnt_dly);
            @(negedge clk);
            if (stall) obs_stall++;
            if (bus_req) begin
                obs_req++;
                obs_we    = bus_we;
                obs_addr  = bus_addr;
                obs_be    = bus_be;
                obs_wdata = bus_wdata;
            end
            if (done) begin
                obs_fin        = 1'b1;
                obs_rdata      = rdata;
                obs_err        = lsu_err;
                obs_stall_done = stall;
                obs_req_done   = bus_req;
            end
            next_cycle();
            if (obs_fin) break;
        end
        rd_en = 1'b0; wr_en = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
        if (!obs_fin) chk("access_bound", 32'(obs_fin), 32'd1);
    endtask

    initial begin
        total = 0; nbad = 0;
        rst = 1'b1; rd_en = 1'b1; wr_en = 1'b0; size = 3'b011; addr = 32'h104;
        wdata = 32'h0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;

        // Reset with a load pending on decode: everything must stay low.
        next_cycle();
        @(negedge clk);
        chk("rst_stall",   32'(stall),   32'd0);
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_done",    32'(done),    32'd0);
        chk("rst_err",     32'(lsu_err), 32'd0);
        chk("rst_be",      32'(bus_be),  32'd0);
        chk("rst_rdata",   rdata,        32'h0);
        chk("rst_addr",    bus_addr,     32'h0);
        next_cycle();
        rst = 1'b0; rd_en = 1'b0;
        next_cycle();

        // lw 0x104, gnt on second REQ cycle, rvalid next cycle.
        run_access(1'b0, 3'b011, 32'h104, 32'h0, 1, 32'hDEADBEEF);
        chk("lw_stall_cycles", 32'(obs_stall), 32'd4);
        chk("lw_req_cycles",   32'(obs_req),   32'd2);
        chk("lw_bus_addr",     obs_addr,       32'h104);
        chk("lw_be",           32'(obs_be),    32'hF);
        chk("lw_we",           32'(obs_we),    32'd0);
        chk("lw_rdata",        obs_rdata,      32'hDEADBEEF);
        chk("lw_done_stall",   32'(obs_stall_done), 32'd0);
        chk("lw_err",          32'(obs_err),   32'd0);

        // lb / lbu at 0x203 take the top lane.
        run_access(1'b0, 3'b001, 32'h203, 32'h0, 0, 32'h80FF1234);
        chk("lb_rdata",    obs_rdata,      32'hFFFFFF80);
        chk("lb_be",       32'(obs_be),    32'h8);
        chk("lb_bus_addr", obs_addr,       32'h200);
        run_access(1'b0, 3'b100, 32'h203, 32'h0, 0, 32'h80FF1234);
        chk("lbu_rdata",   obs_rdata,      32'h00000080);
        chk("lbu_be",      32'(obs_be),    32'h8);

        // Half loads on both halves.
        run_access(1'b0, 3'b010, 32'h202, 32'h0, 0, 32'h80FF1234);
        chk("lh_rdata",    obs_rdata,      32'hFFFF80FF);
        chk("lh_be",       32'(obs_be),    32'hC);
        run_access(1'b0, 3'b101, 32'h200, 32'h0, 0, 32'h80FF1234);
        chk("lhu_rdata",   obs_rdata,      32'h00001234);
        chk("lhu_be",      32'(obs_be),    32'h3);

        // sh 0x302, immediate gnt: REQ straight to DONE.
        run_access(1'b1, 3'b010, 32'h302, 32'h0000ABCD, 0, 32'h0);
        chk("sh_we",           32'(obs_we),    32'd1);
        chk("sh_be",           32'(obs_be),    32'hC);
        chk("sh_wdata",        obs_wdata,      32'hABCDABCD);
        chk("sh_bus_addr",     obs_addr,       32'h300);
        chk("sh_req_cycles",   32'(obs_req),   32'd1);
        chk("sh_stall_cycles", 32'(obs_stall), 32'd2);

        // sb at 0x001.
        run_access(1'b1, 3'b001, 32'h001, 32'h1234565A, 0, 32'h0);
        chk("sb_be",    32'(obs_be), 32'h2);
        chk("sb_wdata", obs_wdata,   32'h5A5A5A5A);

        // Misaligned and illegal accesses: error in the IDLE cycle, no bus activity.
        run_access(1'b0, 3'b011, 32'h101, 32'h0, 0, 32'h0);
        chk("lw_mis_err",   32'(obs_err),   32'd1);
        chk("lw_mis_req",   32'(obs_req),   32'd0);
        chk("lw_mis_stall", 32'(obs_stall), 32'd0);
        chk("lw_mis_rdata", obs_rdata,      32'h0);
        run_access(1'b0, 3'b010, 32'h103, 32'h0, 0, 32'h0);
        chk("lh_mis_err",   32'(obs_err),   32'd1);
        chk("lh_mis_req",   32'(obs_req),   32'd0);
        run_access(1'b1, 3'b100, 32'h100, 32'h0, 0, 32'h0);
        chk("sbu_err",      32'(obs_err),   32'd1);
        run_access(1'b0, 3'b111, 32'h100, 32'h0, 0, 32'h0);
        chk("badsize_err",  32'(obs_err),   32'd1);
        chk("badsize_req",  32'(obs_req),   32'd0);

        // Refill rdata so the timeout's forced zero is visible.
        run_access(1'b0, 3'b011, 32'h600, 32'h0, 0, 32'h0BADF00D);
        chk("pre_to_rdata", obs_rdata, 32'h0BADF00D);

        // Timeout: gnt never comes; 16 REQ cycles then ERR.
        run_access(1'b0, 3'b011, 32'h600, 32'h0, 1000, 32'h0);
        chk("to_req_cycles",   32'(obs_req),   32'd16);
        chk("to_stall_cycles", 32'(obs_stall), 32'd17);
        chk("to_err",          32'(obs_err),   32'd1);
        chk("to_rdata",        obs_rdata,      32'h0);
        chk("to_req_at_err",   32'(obs_req_done), 32'd0);
        @(negedge clk);
        chk("to_err_pulse",    32'(lsu_err),   32'd0);
        chk("to_done_pulse",   32'(done),      32'd0);
        next_cycle();

        // Reset during WAIT_R, then a late rvalid.
        rd_en = 1'b1; size = 3'b011; addr = 32'h400;
        @(negedge clk);
        chk("mr_idle_stall", 32'(stall), 32'd1);
        next_cycle();
        bus_gnt = 1'b1;
        @(negedge clk);
        chk("mr_req", 32'(bus_req), 32'd1);
        next_cycle();
        bus_gnt = 1'b0; rst = 1'b1; rd_en = 1'b0;
        @(negedge clk);
        chk("mr_rst_stall", 32'(stall),   32'd0);
        chk("mr_rst_req",   32'(bus_req), 32'd0);
        next_cycle();
        rst = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("mr_late_done",  32'(done),    32'd0);
        chk("mr_late_req",   32'(bus_req), 32'd0);
        chk("mr_late_stall", 32'(stall),   32'd0);
        chk("mr_late_rdata", rdata,        32'h0);
        next_cycle();
        bus_rvalid = 1'b0;
        @(negedge clk);
        chk("mr_after_rdata", rdata,       32'h0);
        chk("mr_after_done",  32'(done),   32'd0);
        next_cycle();

        // rd_en held through DONE must not launch a second access.
        run_access(1'b0, 3'b011, 32'h500, 32'h0, 0, 32'h11223344);
        chk("hold_rdata",      obs_rdata,            32'h11223344);
        chk("hold_done_stall", 32'(obs_stall_done),  32'd0);
        chk("hold_done_req",   32'(obs_req_done),    32'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("hold_no_req",   32'(bus_req), 32'd0);
            chk("hold_no_stall", 32'(stall),   32'd0);
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, nbad);
        $finish;
    end

endmodule
